// File: rtl/vending_machine_multi_if.sv
// ---------------------------------------------------------------------------
// vending_machine_multi_if
//   Bundle of front-end, dispenser and coin-hopper signals for the
//   multi-product vending controller.
//
//   Front-end inputs (driven by the coin acceptor / keypad / service port):
//     coin_valid, coin_type      coin present and its denomination
//     select_valid, select_id    purchase request
//     cancel                     refund request
//     restock_valid/_id/_count   add units to one product's stock
//   Controller outputs (all registered inside the controller):
//     coin_accept, coin_reject   one-cycle coin verdict
//     dispense_valid/_id         one-cycle dispense command
//     vend_fail, fail_code       one-cycle refusal with reason
//     change_valid, change_coin  one change coin per pulse
//     busy                       refund in progress
//     balance                    current credit
//     stock_empty                per-product sold-out flags
//
//   Modports:
//     master : the front end / environment side
//     slave  : the controller side
// ---------------------------------------------------------------------------
interface vending_machine_multi_if #(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W        = 2,
  parameter int PRICE_W      = 8,
  parameter int STOCK_W      = 4
);
  // front-end -> controller
  logic                    coin_valid;
  logic [1:0]              coin_type;
  logic                    select_valid;
  logic [SEL_W-1:0]        select_id;
  logic                    cancel;
  logic                    restock_valid;
  logic [SEL_W-1:0]        restock_id;
  logic [STOCK_W-1:0]      restock_count;

  // controller -> dispenser / hopper / display
  logic                    coin_accept;
  logic                    coin_reject;
  logic                    dispense_valid;
  logic [SEL_W-1:0]        dispense_id;
  logic                    vend_fail;
  logic [1:0]              fail_code;
  logic                    change_valid;
  logic [1:0]              change_coin;
  logic                    busy;
  logic [PRICE_W-1:0]      balance;
  logic [NUM_PRODUCTS-1:0] stock_empty;

  modport master (
    output coin_valid, coin_type, select_valid, select_id, cancel,
           restock_valid, restock_id, restock_count,
    input  coin_accept, coin_reject, dispense_valid, dispense_id,
           vend_fail, fail_code, change_valid, change_coin, busy,
           balance, stock_empty
  );

  modport slave (
    input  coin_valid, coin_type, select_valid, select_id, cancel,
           restock_valid, restock_id, restock_count,
    output coin_accept, coin_reject, dispense_valid, dispense_id,
           vend_fail, fail_code, change_valid, change_coin, busy,
           balance, stock_empty
  );
endinterface

// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//   Multi-product vending controller. Tracks credit, per-product stock and
//   prices, dispenses on a successful selection and pays change back one
//   coin per cycle (largest of 20/10/5 first). Supports runtime restocking,
//   a credit ceiling, and an inactivity timeout that refunds idle credit.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : vending_machine_multi_if.slave (see interface header for the
//            individual signals)
//
//   Coin / change encoding: 00 = 5, 01 = 10, 10 = 20, 11 = invalid.
//   Fail codes: 01 sold out, 10 insufficient funds, 11 invalid id.
//
//   All outputs are registers; every pulse appears on the edge after the
//   inputs that caused it were sampled.
// ---------------------------------------------------------------------------
module vending_machine_multi #(
  parameter int                                NUM_PRODUCTS   = 4,
  parameter int                                SEL_W          = 2,
  parameter int                                PRICE_W        = 8,
  parameter logic [NUM_PRODUCTS*PRICE_W-1:0]   PRICES         = {8'd35, 8'd20, 8'd10, 8'd5},
  parameter int                                STOCK_W        = 4,
  parameter int                                INIT_STOCK     = 4,
  parameter int                                MAX_BALANCE    = 100,
  parameter int                                TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  vending_machine_multi_if.slave bus
);

  localparam int                 SUM_W      = PRICE_W + 1;
  localparam int                 TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SUM_W-1:0]   MAX_BAL_S  = SUM_W'(MAX_BALANCE);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_CHANGE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t                               state_q, state_d;
  logic [PRICE_W-1:0]                   balance_q, balance_d;
  logic [TMR_W-1:0]                     timer_q, timer_d;
  logic [NUM_PRODUCTS-1:0][STOCK_W-1:0] stock_q, stock_d;
  logic [NUM_PRODUCTS-1:0]              stock_empty_q, stock_empty_d;

  logic                                 coin_accept_q, coin_accept_d;
  logic                                 coin_reject_q, coin_reject_d;
  logic                                 dispense_valid_q, dispense_valid_d;
  logic [SEL_W-1:0]                     dispense_id_q, dispense_id_d;
  logic                                 vend_fail_q, vend_fail_d;
  logic [1:0]                           fail_code_q, fail_code_d;
  logic                                 change_valid_q, change_valid_d;
  logic [1:0]                           change_coin_q, change_coin_d;
  logic                                 busy_q, busy_d;

  // -------------------------------------------------------------------------
  // Price table unpacked from the parameter vector
  // -------------------------------------------------------------------------
  logic [NUM_PRODUCTS-1:0][PRICE_W-1:0] price_tbl;

  for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_price
    assign price_tbl[gi] = PRICES[gi*PRICE_W +: PRICE_W];
  end

  // -------------------------------------------------------------------------
  // Selected-product lookup. An id at or above NUM_PRODUCTS matches no
  // entry, which is how the invalid-id case is detected.
  // -------------------------------------------------------------------------
  logic               sel_in_range;
  logic [PRICE_W-1:0] sel_price;
  logic [STOCK_W-1:0] sel_stock;

  always_comb begin
    sel_in_range = 1'b0;
    sel_price    = '0;
    sel_stock    = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (bus.select_id == SEL_W'(i)) begin
        sel_in_range = 1'b1;
        sel_price    = price_tbl[i];
        sel_stock    = stock_q[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Coin decode and credit check (one extra bit so the ceiling compare
  // cannot be fooled by wrap-around)
  // -------------------------------------------------------------------------
  logic             coin_ok;
  logic [SUM_W-1:0] coin_val;
  logic [SUM_W-1:0] coin_sum;
  logic             coin_fits;

  always_comb begin
    coin_ok  = 1'b1;
    coin_val = '0;
    case (bus.coin_type)
      2'b00:   coin_val = SUM_W'(5);
      2'b01:   coin_val = SUM_W'(10);
      2'b10:   coin_val = SUM_W'(20);
      default: coin_ok  = 1'b0;
    endcase
  end

  assign coin_sum  = {1'b0, balance_q} + coin_val;
  assign coin_fits = coin_ok && (coin_sum <= MAX_BAL_S);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    balance_d        = balance_q;
    timer_d          = timer_q;
    coin_accept_d    = 1'b0;
    coin_reject_d    = 1'b0;
    dispense_valid_d = 1'b0;
    dispense_id_d    = '0;
    vend_fail_d      = 1'b0;
    fail_code_d      = 2'b00;
    change_valid_d   = 1'b0;
    change_coin_d    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (bus.cancel) begin
          // A coin presented together with a cancel is handed back.
          timer_d       = '0;
          coin_reject_d = bus.coin_valid;
          if (balance_q != '0) begin
            state_d = S_CHANGE;
          end
        end else if (bus.select_valid) begin
          timer_d       = '0;
          coin_reject_d = bus.coin_valid;
          if (!sel_in_range) begin
            vend_fail_d = 1'b1;
            fail_code_d = 2'b11;
          end else if (sel_stock == '0) begin
            vend_fail_d = 1'b1;
            fail_code_d = 2'b01;
          end else if (balance_q < sel_price) begin
            vend_fail_d = 1'b1;
            fail_code_d = 2'b10;
          end else begin
            dispense_valid_d = 1'b1;
            dispense_id_d    = bus.select_id;
            balance_d        = balance_q - sel_price;
            // One vend per session: any leftover credit is paid out.
            if (balance_q != sel_price) begin
              state_d = S_CHANGE;
            end
          end
        end else begin
          if (bus.coin_valid) begin
            if (coin_fits) begin
              coin_accept_d = 1'b1;
              balance_d     = coin_sum[PRICE_W-1:0];
            end else begin
              coin_reject_d = 1'b1;
            end
          end

          // Inactivity timer: only runs while credit is held untouched.
          if ((bus.coin_valid && coin_fits) || (balance_q == '0)) begin
            timer_d = '0;
          end else if (timer_q == TMR_LAST) begin
            timer_d = '0;
            state_d = S_CHANGE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end

      S_CHANGE: begin
        timer_d       = '0;
        coin_reject_d = bus.coin_valid;
        if (balance_q >= PRICE_W'(20)) begin
          change_valid_d = 1'b1;
          change_coin_d  = 2'b10;
          balance_d      = balance_q - PRICE_W'(20);
        end else if (balance_q >= PRICE_W'(10)) begin
          change_valid_d = 1'b1;
          change_coin_d  = 2'b01;
          balance_d      = balance_q - PRICE_W'(10);
        end else if (balance_q >= PRICE_W'(5)) begin
          change_valid_d = 1'b1;
          change_coin_d  = 2'b00;
          balance_d      = balance_q - PRICE_W'(5);
        end else begin
          // Credit that no coin can represent is dropped rather than
          // leaving the machine stuck in the refund state.
          balance_d = '0;
        end
        if (balance_d == '0) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CHANGE);
  end

  // -------------------------------------------------------------------------
  // Per-product stock update. Vend decrement and restock add are combined
  // before saturation so a same-cycle vend and restock of one product
  // yields sat(stock - 1 + count). An out-of-range restock_id matches no
  // product and is therefore ignored.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_stock
    logic               vend_hit;
    logic               restock_hit;
    logic [STOCK_W-1:0] stock_base;
    logic [STOCK_W:0]   stock_sum;

    assign vend_hit    = dispense_valid_d && (bus.select_id == SEL_W'(gi));
    assign restock_hit = bus.restock_valid && (bus.restock_id == SEL_W'(gi));
    // A vend only happens when stock is nonzero, so this never underflows.
    assign stock_base  = stock_q[gi] - STOCK_W'(vend_hit);
    assign stock_sum   = {1'b0, stock_base}
                       + (restock_hit ? {1'b0, bus.restock_count} : {(STOCK_W+1){1'b0}});
    assign stock_d[gi] = stock_sum[STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
    assign stock_empty_d[gi] = (stock_d[gi] == '0);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      balance_q        <= '0;
      timer_q          <= '0;
      stock_q          <= {NUM_PRODUCTS{STOCK_INIT}};
      stock_empty_q    <= '0;
      coin_accept_q    <= 1'b0;
      coin_reject_q    <= 1'b0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= '0;
      vend_fail_q      <= 1'b0;
      fail_code_q      <= 2'b00;
      change_valid_q   <= 1'b0;
      change_coin_q    <= 2'b00;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      balance_q        <= balance_d;
      timer_q          <= timer_d;
      stock_q          <= stock_d;
      stock_empty_q    <= stock_empty_d;
      coin_accept_q    <= coin_accept_d;
      coin_reject_q    <= coin_reject_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      vend_fail_q      <= vend_fail_d;
      fail_code_q      <= fail_code_d;
      change_valid_q   <= change_valid_d;
      change_coin_q    <= change_coin_d;
      busy_q           <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.coin_accept    = coin_accept_q;
  assign bus.coin_reject    = coin_reject_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.dispense_id    = dispense_id_q;
  assign bus.vend_fail      = vend_fail_q;
  assign bus.fail_code      = fail_code_q;
  assign bus.change_valid   = change_valid_q;
  assign bus.change_coin    = change_coin_q;
  assign bus.busy           = busy_q;
  assign bus.balance        = balance_q;
  assign bus.stock_empty    = stock_empty_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes the expected output event for every
// cycle that should produce a pulse; monitors pop and compare whenever a
// pulse appears. Two builds: 4 products (short timeout) and 3 products.
module tb_vending_machine_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vending_machine_multi_if #(.NUM_PRODUCTS(4), .SEL_W(2), .PRICE_W(8), .STOCK_W(4)) vif ();
  vending_machine_multi_if #(.NUM_PRODUCTS(3), .SEL_W(2), .PRICE_W(8), .STOCK_W(4)) vif3 ();

  vending_machine_multi #(
    .NUM_PRODUCTS(4), .SEL_W(2), .PRICE_W(8),
    .PRICES({8'd35, 8'd20, 8'd10, 8'd5}),
    .STOCK_W(4), .INIT_STOCK(4), .MAX_BALANCE(100), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(vif)
  );

  vending_machine_multi #(
    .NUM_PRODUCTS(3), .SEL_W(2), .PRICE_W(8),
    .PRICES({8'd20, 8'd10, 8'd5}),
    .STOCK_W(4), .INIT_STOCK(4), .MAX_BALANCE(100), .TIMEOUT_CYCLES(1000)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(vif3)
  );

  // One output event = everything visible on a cycle with any pulse.
  typedef struct packed {
    logic       ca;
    logic       cr;
    logic       dv;
    logic [1:0] did;
    logic       vf;
    logic [1:0] fc;
    logic       cv;
    logic [1:0] cc;
    logic       busy;
    logic [7:0] bal;
  } ev_t;

  ev_t q_main[$];
  ev_t q_3[$];
  ev_t act_m, act_3;
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input logic ca, input logic cr, input logic dv,
                             input logic [1:0] did, input logic vf, input logic [1:0] fc,
                             input logic cv, input logic [1:0] cc, input logic busy,
                             input logic [7:0] bal);
    ev_t e;
    e = {ca, cr, dv, did, vf, fc, cv, cc, busy, bal};
    return e;
  endfunction

  task automatic report(input string tag, input ev_t act, input ev_t exp, input bit have);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected event act=%h (no expectation queued)", tag, act);
    end else if (act !== exp) begin
      errors++;
      $display("FAIL %s event act=%h exp=%h", tag, act, exp);
    end else begin
      $display("ok   %s event %h", tag, act);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitors: sample away from the active edge.
  always @(negedge clk) begin
    if (vif.coin_accept | vif.coin_reject | vif.dispense_valid | vif.vend_fail | vif.change_valid) begin
      act_m = {vif.coin_accept, vif.coin_reject, vif.dispense_valid, vif.dispense_id,
               vif.vend_fail, vif.fail_code, vif.change_valid, vif.change_coin,
               vif.busy, vif.balance};
      if (q_main.size() == 0) report("main", act_m, '0, 1'b0);
      else                    report("main", act_m, q_main.pop_front(), 1'b1);
    end
  end

  always @(negedge clk) begin
    if (vif3.coin_accept | vif3.coin_reject | vif3.dispense_valid | vif3.vend_fail | vif3.change_valid) begin
      act_3 = {vif3.coin_accept, vif3.coin_reject, vif3.dispense_valid, vif3.dispense_id,
               vif3.vend_fail, vif3.fail_code, vif3.change_valid, vif3.change_coin,
               vif3.busy, vif3.balance};
      if (q_3.size() == 0) report("p3", act_3, '0, 1'b0);
      else                 report("p3", act_3, q_3.pop_front(), 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of front-end stimulus on the 4-product build.
  task automatic cyc(input logic cv, input logic [1:0] ct, input logic sv,
                     input logic [1:0] sid, input logic cn);
    vif.coin_valid   = cv;
    vif.coin_type    = ct;
    vif.select_valid = sv;
    vif.select_id    = sid;
    vif.cancel       = cn;
    tick();
    vif.coin_valid   = 1'b0;
    vif.coin_type    = 2'b00;
    vif.select_valid = 1'b0;
    vif.select_id    = 2'b00;
    vif.cancel       = 1'b0;
  endtask

  task automatic cyc3(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] sid);
    vif3.coin_valid   = cv;
    vif3.coin_type    = ct;
    vif3.select_valid = sv;
    vif3.select_id    = sid;
    tick();
    vif3.coin_valid   = 1'b0;
    vif3.coin_type    = 2'b00;
    vif3.select_valid = 1'b0;
    vif3.select_id    = 2'b00;
  endtask

  // Insert a 5 then buy product 0 (price 5); starts and ends at balance 0.
  task automatic buy0();
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd5));
    cyc(1, 2'b00, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,1,2'd0,0,2'b00,0,2'b00,0,8'd0));
    cyc(0, 2'b00, 1, 2'd0, 0);
  endtask

  // Wait (bounded) until every queued expectation has been seen.
  task automatic drain(input string tag);
    int n = 0;
    while ((q_main.size() != 0 || q_3.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (q_main.size() != 0 || q_3.size() != 0) begin
      errors++;
      $display("FAIL %s drain act=%0d pending exp=0 pending", tag, q_main.size() + q_3.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.coin_valid = 0; vif.coin_type = 0; vif.select_valid = 0; vif.select_id = 0;
    vif.cancel = 0; vif.restock_valid = 0; vif.restock_id = 0; vif.restock_count = 0;
    vif3.coin_valid = 0; vif3.coin_type = 0; vif3.select_valid = 0; vif3.select_id = 0;
    vif3.cancel = 0; vif3.restock_valid = 0; vif3.restock_id = 0; vif3.restock_count = 0;

    // ---- reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_balance", vif.balance, 0);
    chk("rst_stock_empty", vif.stock_empty, 0);
    chk("rst_busy", vif.busy, 0);
    chk("rst_pulses", {vif.coin_accept, vif.coin_reject, vif.dispense_valid, vif.vend_fail, vif.change_valid}, 0);
    chk("rst_codes", {vif.dispense_id, vif.fail_code, vif.change_coin}, 0);
    chk("rst_p3_balance", vif3.balance, 0);

    // ---- 1: 20+20, buy id3 (35), 5 back
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd20));
    cyc(1, 2'b10, 0, 2'd0, 0);
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd40));
    cyc(1, 2'b10, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,1,2'd3,0,2'b00,0,2'b00,1,8'd5));
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b00,0,8'd0));
    cyc(0, 2'b00, 1, 2'd3, 0);
    chk("t1_busy", vif.busy, 1);
    tick();
    chk("t1_busy_fall", vif.busy, 0);
    drain("t1");

    // ---- 2: sell out product 0, then a sold-out refusal
    for (int k = 0; k < 4; k++) begin
      buy0();
      chk("t2_empty0", vif.stock_empty[0], (k == 3) ? 32'd1 : 32'd0);
    end
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd5));
    cyc(1, 2'b00, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,0,2'd0,1,2'b01,0,2'b00,0,8'd5));
    cyc(0, 2'b00, 1, 2'd0, 0);
    chk("t2_stock_empty", vif.stock_empty, 4'b0001);
    drain("t2");

    // ---- 3: insufficient funds, then refund
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd10));
    cyc(1, 2'b00, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,0,2'd0,1,2'b10,0,2'b00,0,8'd10));
    cyc(0, 2'b00, 1, 2'd2, 0);
    chk("t3_stock_empty", vif.stock_empty, 4'b0001);
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b01,0,8'd0));
    cyc(0, 2'b00, 0, 2'd0, 1);
    drain("t3");

    // ---- 3b: three-product build, invalid id and funds checks
    q_3.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd10));
    cyc3(1, 2'b01, 0, 2'd0);
    q_3.push_back(mk(0,0,0,2'd0,1,2'b11,0,2'b00,0,8'd10));
    cyc3(0, 2'b00, 1, 2'd3);
    q_3.push_back(mk(0,0,0,2'd0,1,2'b10,0,2'b00,0,8'd10));
    cyc3(0, 2'b00, 1, 2'd2);
    chk("t3b_stock_empty", vif3.stock_empty, 3'b000);
    q_3.push_back(mk(0,0,1,2'd1,0,2'b00,0,2'b00,0,8'd0));
    cyc3(0, 2'b00, 1, 2'd1);
    drain("t3b");

    // ---- 4: 35 refunded as 20,10,5; coin and select during refund
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd20));
    cyc(1, 2'b10, 0, 2'd0, 0);
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd30));
    cyc(1, 2'b01, 0, 2'd0, 0);
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd35));
    cyc(1, 2'b00, 0, 2'd0, 0);
    cyc(0, 2'b00, 0, 2'd0, 1);
    chk("t4_busy", vif.busy, 1);
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b10,1,8'd15));
    cyc(0, 2'b00, 1, 2'd0, 0);
    q_main.push_back(mk(0,1,0,2'd0,0,2'b00,1,2'b01,1,8'd5));
    cyc(1, 2'b00, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b00,0,8'd0));
    tick();
    drain("t4");

    // ---- 5: balance ceiling, invalid coin, coin alongside select
    for (int k = 0; k < 5; k++) begin
      q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'(20 * (k + 1))));
      cyc(1, 2'b10, 0, 2'd0, 0);
    end
    q_main.push_back(mk(0,1,0,2'd0,0,2'b00,0,2'b00,0,8'd100));
    cyc(1, 2'b10, 0, 2'd0, 0);
    q_main.push_back(mk(0,1,0,2'd0,0,2'b00,0,2'b00,0,8'd100));
    cyc(1, 2'b11, 0, 2'd0, 0);
    q_main.push_back(mk(0,1,1,2'd3,0,2'b00,0,2'b00,1,8'd65));
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b10,1,8'd45));
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b10,1,8'd25));
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b10,1,8'd5));
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b00,0,8'd0));
    cyc(1, 2'b00, 1, 2'd3, 0);
    drain("t5");

    // ---- 6a: inactivity timeout (16 idle cycles)
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd5));
    cyc(1, 2'b00, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b00,0,8'd0));
    repeat (15) tick();
    chk("t6_busy_pre", vif.busy, 0);
    chk("t6_balance_pre", vif.balance, 5);
    tick();
    chk("t6_busy_timeout", vif.busy, 1);
    drain("t6a");

    // ---- 6b: reset in the middle of a refund
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd20));
    cyc(1, 2'b10, 0, 2'd0, 0);
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd40));
    cyc(1, 2'b10, 0, 2'd0, 0);
    q_main.push_back(mk(0,0,0,2'd0,0,2'b00,1,2'b10,1,8'd20));
    cyc(0, 2'b00, 0, 2'd0, 1);
    tick();
    chk("t6b_pre_empty", vif.stock_empty, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6b_balance", vif.balance, 0);
    chk("t6b_busy", vif.busy, 0);
    chk("t6b_pulses", {vif.coin_accept, vif.coin_reject, vif.dispense_valid, vif.vend_fail, vif.change_valid}, 0);
    chk("t6b_stock_empty", vif.stock_empty, 0);
    drain("t6b");

    // ---- 6c: restock saturation (4 + 15 -> 15)
    vif.restock_valid = 1'b1; vif.restock_id = 2'd0; vif.restock_count = 4'd15;
    tick();
    vif.restock_valid = 1'b0; vif.restock_count = 4'd0;
    for (int k = 0; k < 15; k++) begin
      buy0();
      if (k >= 13) chk("t6c_sat_empty0", vif.stock_empty[0], (k == 14) ? 32'd1 : 32'd0);
    end

    // ---- 6d: same-cycle vend and restock: 1 - 1 + 2 = 2
    vif.restock_valid = 1'b1; vif.restock_id = 2'd0; vif.restock_count = 4'd1;
    tick();
    vif.restock_valid = 1'b0; vif.restock_count = 4'd0;
    q_main.push_back(mk(1,0,0,2'd0,0,2'b00,0,2'b00,0,8'd5));
    cyc(1, 2'b00, 0, 2'd0, 0);
    vif.restock_valid = 1'b1; vif.restock_id = 2'd0; vif.restock_count = 4'd2;
    q_main.push_back(mk(0,0,1,2'd0,0,2'b00,0,2'b00,0,8'd0));
    cyc(0, 2'b00, 1, 2'd0, 0);
    vif.restock_valid = 1'b0; vif.restock_count = 4'd0;
    chk("t6d_empty0_a", vif.stock_empty[0], 0);
    buy0();
    chk("t6d_empty0_b", vif.stock_empty[0], 0);
    buy0();
    chk("t6d_empty0_c", vif.stock_empty[0], 1);
    drain("t6d");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parameterised multi-product vending controller, the next generation of the team's single-purchase vending block. It supports NUM_PRODUCTS products with per-product prices and stock counters, and returns change coin-by-coin through an explicit change state machine. It adds runtime restocking, balance capping, an inactivity refund timeout and coded failure reporting. It sits between the coin acceptor/keypad front end and the dispenser and coin-hopper drivers.

Parameters:
NUM_PRODUCTS, 4, number of products; must satisfy 2 <= NUM_PRODUCTS <= 2^SEL_W
SEL_W, 2, width of product index ports
PRICE_W, 8, width of prices and balance
PRICES, {8'd35,8'd20,8'd10,8'd5}, packed prices; product i at [i*PRICE_W +: PRICE_W]; every price must be a nonzero multiple of 5
STOCK_W, 4, width of each stock counter
INIT_STOCK, 4, stock loaded into every product on reset
MAX_BALANCE, 100, balance ceiling in units
TIMEOUT_CYCLES, 1000, idle cycles with nonzero balance before automatic refund

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
coin_valid  in  1  coin present this cycle
coin_type  in  2  00=5, 01=10, 10=20, 11=invalid
select_valid  in  1  purchase request strobe
select_id  in  SEL_W  requested product
cancel  in  1  refund request
restock_valid  in  1  restock strobe
restock_id  in  SEL_W  product to restock
restock_count  in  STOCK_W  units to add
coin_accept  out  1  pulse: coin credited
coin_reject  out  1  pulse: coin returned unaccepted
dispense_valid  out  1  pulse: product dispensed
dispense_id  out  SEL_W  product dispensed; valid with dispense_valid, else 0
vend_fail  out  1  pulse: purchase refused
fail_code  out  2  01 sold out, 10 insufficient funds, 11 invalid id; 00 when vend_fail=0
change_valid  out  1  pulse: one change coin released
change_coin  out  2  coin released, same encoding as coin_type; 0 when change_valid=0
busy  out  1  high while in CHANGE
balance  out  PRICE_W  current credit
stock_empty  out  NUM_PRODUCTS  bit i high when stock i is 0

Behaviour:
- All outputs are registered. Pulses last exactly one cycle and appear on the edge after the input is sampled.
- Reset (rst=1 at a clock edge): all outputs 0, balance 0, every stock = INIT_STOCK (stock_empty = 0), state IDLE, timer 0. Reset during CHANGE aborts the refund and discards the remaining balance.
- FSM states: IDLE and CHANGE.
- IDLE, per-cycle priority is cancel > select_valid > coin_valid:
  - cancel: if balance > 0, go to CHANGE; otherwise no effect.
  - select_valid: failure checks in order are invalid id (select_id >= NUM_PRODUCTS) -> 11, stock 0 -> 01, balance < price -> 10. A failure pulses vend_fail and leaves balance and stock unchanged.
  - Successful select: dispense_valid=1, dispense_id=select_id, balance -= price, stock -= 1. If the new balance > 0, go to CHANGE on the same edge (one vend per session).
  - Coin accepted only when no cancel/select fires, coin_type != 11, and balance + value <= MAX_BALANCE. Accept: coin_accept, balance += value. Otherwise coin_reject. A coin arriving alongside cancel or select is rejected.
- Timer: counts IDLE cycles with balance > 0. It clears on any accepted coin, any select (pass or fail), cancel, or whenever balance = 0. On reaching TIMEOUT_CYCLES, go to CHANGE.
- CHANGE: busy=1. Each cycle, release the largest coin from {20, 10, 5} that is <= balance: change_valid=1, balance -= coin. Return to IDLE on the edge where balance reaches 0. Defensive case: a nonzero balance below 5 is cleared, no coin is released, and the FSM returns to IDLE. Every coin_valid in CHANGE is rejected; select and cancel are ignored (no pulses).
- Restock works in any state and in parallel with the FSM:
  - stock[id] += restock_count, saturating at 2^STOCK_W - 1.
  - An invalid restock_id is ignored.
  - Same-cycle vend and restock of one product: result = sat(stock - 1 + count).
- Arithmetic: internal sums use PRICE_W+1 bits; balance never exceeds MAX_BALANCE and never underflows.

Test Plan:
1. Reset; coins 20, 20; select id 3 (price 35) -> dispense_valid, dispense_id=3, balance 5; next cycle change_valid with coin 00 (5), balance 0, busy falls.
2. With INIT_STOCK=4, buy id 0 four times (coin 5 each) -> stock_empty[0]=1; fifth attempt with balance 5 -> vend_fail, fail_code 01, balance stays 5.
3. Balance 10, select id 2 -> fail_code 10. Build with NUM_PRODUCTS=3, select id 3 -> fail_code 11. Stock unchanged in both cases.
4. Balance 35, cancel -> change coins 20, 10, 5 on three consecutive cycles, busy=1 throughout. A coin inserted mid-refund -> coin_reject, balance unaffected.
5. Five 20s give balance 100 -> sixth 20 rejected, balance stays 100. coin_type 11 -> coin_reject. Coin sent together with select -> coin rejected, select processed.
6. TIMEOUT_CYCLES=16: insert 5, idle 16 cycles -> change 5 released. Restock id 0 by 15 from stock 4 -> saturates at 15. rst asserted mid-CHANGE -> all outputs 0 and stock=INIT_STOCK after the next edge.
